// File: rtl/demux_seq_ctrl.sv
// demux_seq_ctrl: feeds a 1-to-8 bit demultiplexer from a valid/ready bit stream.
// Each enabled channel gets BURST_LEN bits in ascending index order. GAP_CYCLES
// idle cycles separate consecutive channels.
// Optional build macro DEMUX_SEQ_WRAP_EN: after the last enabled channel the
// sequence wraps to the lowest enabled channel and runs until abort or rst.
module demux_seq_ctrl #(
    parameter int BURST_LEN  = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] chan_en,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    output logic       demux_i,
    output logic [2:0] demux_s,
    output logic       busy,
    output logic       frame_done,
    output logic       err_no_chan
);

    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

    state_t     state, state_nxt;
    logic [7:0] mask, mask_nxt;
    logic [2:0] chan, chan_nxt;
    logic [7:0] bit_cnt, bit_cnt_nxt;
    logic [7:0] gap_cnt, gap_cnt_nxt;
    logic       demux_i_nxt;
    logic [2:0] demux_s_nxt;
    logic       frame_done_nxt;
    logic       err_nxt;
    logic       accept;
    logic       advance;
    logic [3:0] above;
    logic [2:0] first_en;

    // {found, index} of the lowest set mask bit strictly above channel c
    function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] c);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            if (i > int'(c) && m[i]) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    // index of the lowest set bit; caller guarantees m is non-zero
    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    // ready depends on state only, so there is no in_valid -> in_ready path
    assign in_ready = (state == DRIVE);
    assign busy     = (state != IDLE);
    // an abort discards any bit offered in the same cycle
    assign accept   = in_valid & in_ready & ~abort;
    assign above    = next_above(mask, chan);
    assign first_en = lowest_set(chan_en);

    // next-state, counters and registered-output values
    always_comb begin
        state_nxt      = state;
        mask_nxt       = mask;
        chan_nxt       = chan;
        bit_cnt_nxt    = bit_cnt;
        gap_cnt_nxt    = gap_cnt;
        demux_i_nxt    = 1'b0;
        demux_s_nxt    = demux_s;
        frame_done_nxt = 1'b0;
        err_nxt        = 1'b0;
        advance        = 1'b0;

        if (accept) begin
            demux_i_nxt = in_bit;
            demux_s_nxt = chan;
        end

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    if (chan_en == 8'd0) begin
                        err_nxt = 1'b1;
                    end else begin
                        mask_nxt    = chan_en;
                        chan_nxt    = first_en;
                        bit_cnt_nxt = 8'd0;
                        state_nxt   = DRIVE;
                    end
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (accept) begin
                    if (bit_cnt == 8'(BURST_LEN - 1)) begin
                        if (GAP_CYCLES > 0) begin
                            state_nxt   = GAP;
                            gap_cnt_nxt = 8'd0;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + 8'd1;
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (gap_cnt == 8'(GAP_CYCLES - 1)) begin
                    advance = 1'b1;
                end else begin
                    gap_cnt_nxt = gap_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // move on to the next enabled channel or close the pass
        if (advance) begin
            if (above[3]) begin
                chan_nxt    = above[2:0];
                bit_cnt_nxt = 8'd0;
                state_nxt   = DRIVE;
            end else begin
                frame_done_nxt = 1'b1;
`ifdef DEMUX_SEQ_WRAP_EN
                chan_nxt    = lowest_set(mask);
                bit_cnt_nxt = 8'd0;
                state_nxt   = DRIVE;
`else
                state_nxt   = IDLE;
`endif
            end
        end
    end

    // state and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mask        <= 8'd0;
            chan        <= 3'd0;
            bit_cnt     <= 8'd0;
            gap_cnt     <= 8'd0;
            demux_i     <= 1'b0;
            demux_s     <= 3'd0;
            frame_done  <= 1'b0;
            err_no_chan <= 1'b0;
        end else begin
            state       <= state_nxt;
            mask        <= mask_nxt;
            chan        <= chan_nxt;
            bit_cnt     <= bit_cnt_nxt;
            gap_cnt     <= gap_cnt_nxt;
            demux_i     <= demux_i_nxt;
            demux_s     <= demux_s_nxt;
            frame_done  <= frame_done_nxt;
            err_no_chan <= err_nxt;
        end
    end

endmodule

// File: tb/tb_demux_seq_ctrl.sv
// Bench for demux_seq_ctrl: table vectors, directed multi-cycle sequences and
// random traffic checked against a schedule-queue reference model.
// Build with DEMUX_SEQ_WRAP_EN defined to exercise the wrap-around variant.
module tb_demux_seq_ctrl;

`ifdef DEMUX_SEQ_WRAP_EN
    localparam int BL = 1;
    localparam int GC = 0;
`else
    localparam int BL = 4;
    localparam int GC = 1;
`endif

    logic       clk = 1'b0;
    logic       rst, start, abort, in_valid, in_bit;
    logic [7:0] chan_en;
    logic       in_ready, demux_i, busy, frame_done, err_no_chan;
    logic [2:0] demux_s;

    demux_seq_ctrl #(.BURST_LEN(BL), .GAP_CYCLES(GC)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .chan_en(chan_en),
        .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
        .demux_i(demux_i), .demux_s(demux_s), .busy(busy),
        .frame_done(frame_done), .err_no_chan(err_no_chan)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: a frame is a schedule of slots, one per channel bit
    // (value = channel index, waits for a valid bit) or per gap cycle (-1).
    int         q[$];
    logic [7:0] m_mask  = 8'd0;
    logic [2:0] m_s     = 3'd0;
    logic       m_known = 1'b0;

    logic       p_ready, p_busy;
    logic       o_i, o_fd, o_err;
    logic [2:0] o_s;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void build(input logic [7:0] m);
        for (int ch = 0; ch < 8; ch++) begin
            if (m[ch]) begin
                for (int k = 0; k < BL; k++) q.push_back(ch);
                for (int k = 0; k < GC; k++) q.push_back(-1);
            end
        end
    endfunction

    // one clock cycle: drive, check pre-edge outputs, advance model, check post-edge
    task automatic cyc(input logic r, input logic st, input logic ab,
                       input logic [7:0] en, input logic v, input logic b);
        logic m_ready, m_busy, m_i, m_fd, m_err;
        rst = r; start = st; abort = ab; chan_en = en; in_valid = v; in_bit = b;
        #1;
        p_ready = in_ready;
        p_busy  = busy;
        m_busy  = (q.size() > 0);
        m_ready = m_busy && (q[0] >= 0);
        if (m_known) begin
            chk("in_ready", {7'd0, p_ready}, {7'd0, m_ready});
            chk("busy", {7'd0, p_busy}, {7'd0, m_busy});
        end
        m_i = 1'b0; m_fd = 1'b0; m_err = 1'b0;
        if (r) begin
            q.delete();
            m_s     = 3'd0;
            m_known = 1'b1;
        end else if (q.size() == 0) begin
            if (st && !ab) begin
                if (en == 8'd0) m_err = 1'b1;
                else begin
                    m_mask = en;
                    build(en);
                end
            end
        end else if (ab) begin
            q.delete();
        end else begin
            if (q[0] < 0) begin
                void'(q.pop_front());
            end else if (v) begin
                m_i = b;
                m_s = 3'(q[0]);
                void'(q.pop_front());
            end
            if (q.size() == 0) begin
                m_fd = 1'b1;
`ifdef DEMUX_SEQ_WRAP_EN
                build(m_mask);
`endif
            end
        end
        @(posedge clk);
        @(negedge clk);
        o_i = demux_i; o_s = demux_s; o_fd = frame_done; o_err = err_no_chan;
        if (m_known) begin
            chk("demux_i", {7'd0, o_i}, {7'd0, m_i});
            chk("demux_s", {5'd0, o_s}, {5'd0, m_s});
            chk("frame_done", {7'd0, o_fd}, {7'd0, m_fd});
            chk("err_no_chan", {7'd0, o_err}, {7'd0, m_err});
        end
    endtask

    typedef struct {
        logic       st;
        logic [7:0] en;
        logic       v;
        logic       b;
        logic       x_ready;
        logic       x_busy;
        logic       x_i;
        logic [2:0] x_s;
        logic       x_fd;
        logic       x_err;
    } vec_t;

    vec_t tbl[14];

    initial begin
        // error path, then channel 4 with valid toggling, then gap and done
        tbl[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 8'h10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 8'h10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 8'h10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 8'h10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 8'h10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0};

        cyc(1, 0, 0, 8'h00, 0, 0);
        cyc(1, 0, 0, 8'h00, 0, 0);

`ifndef DEMUX_SEQ_WRAP_EN
        // table vectors
        for (int t = 0; t < 14; t++) begin
            cyc(0, tbl[t].st, 0, tbl[t].en, tbl[t].v, tbl[t].b);
            chk("tbl_ready", {7'd0, p_ready}, {7'd0, tbl[t].x_ready});
            chk("tbl_busy", {7'd0, p_busy}, {7'd0, tbl[t].x_busy});
            chk("tbl_demux_i", {7'd0, o_i}, {7'd0, tbl[t].x_i});
            chk("tbl_demux_s", {5'd0, o_s}, {5'd0, tbl[t].x_s});
            chk("tbl_frame_done", {7'd0, o_fd}, {7'd0, tbl[t].x_fd});
            chk("tbl_err", {7'd0, o_err}, {7'd0, tbl[t].x_err});
        end

        // full frame over channels 0, 2, 7 with bits 1,0,1,1 and one gap cycle each
        begin
            logic [3:0] pat;
            int         chs[3];
            int         fd_cnt;
            pat = 4'b1101;
            chs = '{0, 2, 7};
            fd_cnt = 0;
            cyc(0, 1, 0, 8'b1000_0101, 0, 0);
            for (int k = 0; k < 15; k++) begin
                cyc(0, 0, 0, 8'h00, 1, (k % 5 < 4) ? pat[k % 5] : 1'b0);
                chk("ff_busy", {7'd0, p_busy}, 8'd1);
                chk("ff_demux_s", {5'd0, o_s}, 8'(chs[k / 5]));
                chk("ff_demux_i", {7'd0, o_i}, (k % 5 < 4) ? {7'd0, pat[k % 5]} : 8'd0);
                if (o_fd) fd_cnt++;
            end
            chk("ff_done_last", {7'd0, o_fd}, 8'd1);
            chk("ff_done_count", 8'(fd_cnt), 8'd1);
            cyc(0, 0, 0, 8'h00, 1, 1);
            chk("ff_busy_fell", {7'd0, p_busy}, 8'd0);
        end

        // abort on the second accept of channel 3 with a simultaneous start
        cyc(0, 1, 0, 8'h08, 0, 0);
        cyc(0, 0, 0, 8'h00, 1, 1);
        chk("ab_first_s", {5'd0, o_s}, 8'd3);
        cyc(0, 1, 1, 8'hff, 1, 1);
        chk("ab_demux_i", {7'd0, o_i}, 8'd0);
        chk("ab_no_done", {7'd0, o_fd}, 8'd0);
        cyc(0, 0, 0, 8'h00, 1, 1);
        chk("ab_idle_busy", {7'd0, p_busy}, 8'd0);
        chk("ab_idle_ready", {7'd0, p_ready}, 8'd0);
        chk("ab_after_done", {7'd0, o_fd}, 8'd0);
`else
        // wrap: channels 0 and 1, one bit each, no gap
        cyc(0, 1, 0, 8'h03, 0, 0);
        for (int k = 0; k < 8; k++) begin
            cyc(0, 0, 0, 8'h00, 1, k[0]);
            chk("wr_busy", {7'd0, p_busy}, 8'd1);
            chk("wr_demux_s", {5'd0, o_s}, 8'(k % 2));
            chk("wr_demux_i", {7'd0, o_i}, {7'd0, k[0]});
            chk("wr_done", {7'd0, o_fd}, (k % 2 == 1) ? 8'd1 : 8'd0);
        end
        cyc(0, 0, 1, 8'h00, 1, 1);
        chk("wr_abort_done", {7'd0, o_fd}, 8'd0);
        cyc(0, 0, 0, 8'h00, 0, 0);
        chk("wr_abort_busy", {7'd0, p_busy}, 8'd0);
`endif

        // reset asserted for two cycles in the middle of a burst
        cyc(0, 1, 0, 8'h24, 0, 0);
        cyc(0, 0, 0, 8'h00, 1, 1);
        cyc(1, 0, 0, 8'h00, 1, 1);
        cyc(1, 0, 0, 8'h00, 1, 1);
        chk("rs_demux_i", {7'd0, o_i}, 8'd0);
        chk("rs_demux_s", {5'd0, o_s}, 8'd0);
        chk("rs_done", {7'd0, o_fd}, 8'd0);
        cyc(0, 0, 0, 8'h00, 1, 1);
        chk("rs_busy", {7'd0, p_busy}, 8'd0);
        chk("rs_ready", {7'd0, p_ready}, 8'd0);
        cyc(0, 1, 0, 8'h01, 0, 0);
        for (int k = 0; k < 6; k++) cyc(0, 0, 0, 8'h00, 1, 1'(k));
        cyc(0, 0, 1, 8'h00, 0, 0);

        // random traffic against the model
        for (int k = 0; k < 800; k++) begin
            logic [7:0] en;
            en = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 31) == 0, en, 1'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_seq_ctrl.md
Name: demux_seq_ctrl

Overview:
- Upstream controller for the 1-to-8 bit demultiplexer.
- Accepts a serial bit stream over a valid/ready handshake and drives the demux data bit and 3-bit select.
- Delivers BURST_LEN bits to each enabled channel in ascending index order, with optional idle gap cycles between channels.
- Reports frame completion and error conditions.

Parameters:
- BURST_LEN, 4, bits delivered per channel before advancing; legal range 1..255.
- GAP_CYCLES, 1, idle cycles between channels; legal range 0..255. A value of 0 means no GAP state.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a frame; honoured only in IDLE.
- abort  input  1  terminate the frame; returns to IDLE next cycle.
- chan_en  input  8  channel enable mask; latched on accepted start.
- in_valid  input  1  upstream bit valid.
- in_bit  input  1  upstream data bit.
- in_ready  output  1  controller can accept a bit this cycle.
- demux_i  output  1  registered data bit to the demux data input.
- demux_s  output  3  registered channel select to the demux.
- busy  output  1  high in any state other than IDLE.
- frame_done  output  1  one-cycle pulse after the last enabled channel completes.
- err_no_chan  output  1  one-cycle pulse when start arrives with chan_en==0.

Behaviour:
- Reset (rst=1 at clk edge):
  - State goes to IDLE.
  - All outputs go to 0: in_ready, demux_i, demux_s, busy, frame_done, err_no_chan.
  - Latched mask, bit counter and gap counter clear.
  - Reset overrides every other input, including mid-frame.
- States are IDLE, DRIVE and GAP.
- IDLE:
  - in_ready=0 and demux_i=0.
  - demux_s holds its last value.
  - start with chan_en!=0: latch chan_en, set channel to the lowest set bit, clear the bit counter, go to DRIVE.
  - start with chan_en==0: pulse err_no_chan for one cycle and stay in IDLE.
- DRIVE:
  - in_ready=1, driven combinationally from state.
  - On an accept (in_valid & in_ready), the next cycle has demux_i=in_bit and demux_s=channel. Latency is 1 cycle.
  - In every non-accept cycle, demux_i=0 on the next cycle; demux_s holds.
  - The bit counter increments on each accept.
  - On the accept that completes BURST_LEN bits: go to GAP if GAP_CYCLES>0, otherwise perform ADVANCE.
- GAP:
  - in_ready=0 and demux_i=0.
  - Stay exactly GAP_CYCLES cycles, then perform ADVANCE.
- ADVANCE (an action, not a state):
  - Find the next set bit of the latched mask strictly above the current channel.
  - If one exists: channel takes that index, the bit counter clears, go to DRIVE.
  - If none exists: pulse frame_done in the cycle after the final transition and go to IDLE.
  - With GAP_CYCLES=0, the first bit of the next channel may be accepted in the cycle immediately after the last bit of the previous channel.
- Mask changes: chan_en changes after the latch are ignored until the next start.
- start while busy: ignored.
- abort:
  - From DRIVE or GAP: next cycle is IDLE with in_ready=0 and demux_i=0.
  - No frame_done pulse, and any in-flight accept in the same cycle is discarded.
  - abort has priority over start.
  - abort in IDLE has no effect.
- in_bit is ignored when in_valid=0 or in_ready=0.
- No combinational path exists from in_valid to in_ready.

Optional Feature:
- Macro DEMUX_SEQ_WRAP_EN.
- Defined:
  - After the last enabled channel, ADVANCE wraps to the lowest enabled channel and stays in DRIVE.
  - frame_done still pulses once per completed pass.
  - The frame runs until abort or rst.
  - busy stays 1 throughout.
- Undefined: the frame ends in IDLE after one pass, as described in Behaviour.

Test Plan:
- Reset check: assert rst for 2 cycles mid-DRIVE → all outputs 0 and state IDLE on the next cycle; a subsequent start with chan_en=8'h01 behaves normally.
- Full frame (BURST_LEN=4, GAP_CYCLES=1, chan_en=8'b1000_0101, continuous in_valid, bits 1,0,1,1 repeated):
  - demux_s sequence is 0,0,0,0 then a 1-cycle gap, 2,2,2,2 then gap, 7,7,7,7.
  - demux_i mirrors the input bits, delayed 1 cycle.
  - frame_done pulses once and busy falls.
- Backpressure gaps: in_valid toggled 1,0,1,0 with chan_en=8'h10 → demux_i=0 in the non-accept cycles, demux_s=4 held, and exactly 4 accepts complete the channel.
- Error path: start with chan_en=0 → err_no_chan=1 for exactly one cycle, busy stays 0, in_ready stays 0.
- Abort mid-burst: abort on the 2nd accept of channel 3 → next cycle IDLE, demux_i=0, no frame_done; a start in the same cycle as abort is ignored.
- Wrap feature (DEMUX_SEQ_WRAP_EN defined, GAP_CYCLES=0, chan_en=8'b0000_0011, BURST_LEN=1) → demux_s sequence 0,1,0,1,…, frame_done pulses every 2 accepts, busy=1 until abort.
